// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared types and constants for the RV32I instruction-fetch stage:
//            PC-source encodings, fetch FSM states, FIFO entry layout, and the
//            bubble instruction.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  localparam int XLEN = 32;

  // EX-stage PC source select; 2'b11 behaves like PCSRC_BR
  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Instruction fetches are always word aligned
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Bundles the fetch stage's hazard/redirect inputs, the instruction
//            memory req/gnt/rvalid handshake and the IF/ID register outputs.
//            master = fetch unit side, slave = surrounding pipeline/memory.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
  parameter int XLEN = fetch_unit_pkg::XLEN
);
  // hazard unit
  logic            stallF;
  logic            stallD;
  logic            flushD;
  // redirect sources
  logic [1:0]      pcsrcE;
  logic [XLEN-1:0] pctargetE;
  logic [XLEN-1:0] aluresultE;
  logic            jalD;
  logic [XLEN-1:0] pctargetD;
  // instruction memory
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  // IF/ID pipeline register
  logic [31:0]     instrD;
  logic [XLEN-1:0] pcD;
  logic [XLEN-1:0] pcplus4D;
  logic            validD;

  modport master (
    input  stallF, stallD, flushD,
    input  pcsrcE, pctargetE, aluresultE, jalD, pctargetD,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instrD, pcD, pcplus4D, validD
  );

  modport slave (
    output stallF, stallD, flushD,
    output pcsrcE, pctargetE, aluresultE, jalD, pctargetD,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instrD, pcD, pcplus4D, validD
  );
endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Small synchronous FIFO holding fetched {pc, instr} entries.
//            DEPTH must be a power of two (pointers wrap naturally).
//            clear takes priority over push and pop.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 64,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CW-1:0]     count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_q;
  logic [AW-1:0]     wr_q;
  logic [CW-1:0]     count_q;

  logic w_do_push;
  logic w_do_pop;

  // A push into a full FIFO is only accepted when a pop frees a slot
  assign w_do_push = push_i & (!full_o | pop_i);
  assign w_do_pop  = pop_i & !empty_o;

  assign full_o  = (count_q == C_DEPTH);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_q];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (w_do_push) wr_q <= wr_q + 1'b1;
      if (w_do_pop)  rd_q <= rd_q + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write; contents need no reset since empty_o gates their use
  always_ff @(posedge clk) begin
    if (w_do_push && !clear_i) mem_q[wr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : RV32I IF stage. Owns the PC, issues word fetches with a single
//            outstanding request, buffers responses in fetch_fifo and drives
//            the IF/ID register. Redirects from EX (branch/jalr) beat ID (jal).
// Options  : FETCH_PERF_EN - adds saturating perf counters perf_fetched_o,
//            perf_discarded_o and perf_bubbles_o.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [fetch_unit_pkg::XLEN-1:0] RESET_PC  = '0,
  parameter int                              BUF_DEPTH = 2,
  parameter logic [31:0]                     NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_discarded_o,
  output logic [31:0] perf_bubbles_o
`endif
);
  import fetch_unit_pkg::*;

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(BUF_DEPTH);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pcF_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic [31:0]     instrD_q;
  logic [XLEN-1:0] pcD_q;
  logic [XLEN-1:0] pcplus4D_q;
  logic            validD_q;

  logic            w_redirect;
  logic [XLEN-1:0] w_target_raw;
  logic [XLEN-1:0] w_target;
  logic            w_req;
  logic            w_push;
  logic            w_fifo_push;
  logic            w_pop;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic [CW-1:0]   w_fifo_count;

  // Redirect selection: EX source wins over ID jal
  always_comb begin
    w_redirect   = (bus.pcsrcE != PCSRC_SEQ) | bus.jalD;
    w_target_raw = bus.pctargetD;
    case (bus.pcsrcE)
      PCSRC_JALR: w_target_raw = bus.aluresultE;
      PCSRC_BR:   w_target_raw = bus.pctargetE;
      PCSRC_SEQ:  w_target_raw = bus.pctargetD;
      default:    w_target_raw = bus.pctargetE;
    endcase
    w_target = align_word(w_target_raw);
  end

  // Issue only from IDLE with room guaranteed for the response
  assign w_req = !rst && (state_q == ST_IDLE) && !bus.stallF && !w_redirect
                 && (w_fifo_count < C_DEPTH);

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = pcF_q;

  // A response arriving with a redirect is stale and dropped
  assign w_push       = (state_q == ST_WAIT) && bus.imem_rvalid && !w_redirect;
  assign w_pop        = !bus.flushD && !bus.stallD && !w_fifo_empty;
  assign w_fifo_push  = w_push && (!w_fifo_full || w_pop);
  assign w_push_entry = '{pc: inflight_pc_q, instr: bus.imem_rdata};

  fetch_fifo #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (ENTRY_W),
    .CW     (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_fifo_push),
    .pop_i   (w_pop),
    .clear_i (w_redirect),
    .data_i  (w_push_entry),
    .data_o  (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  // Fetch FSM and PC: one outstanding request, stale responses discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pcF_q         <= RESET_PC;
      inflight_pc_q <= '0;
    end else if (w_redirect) begin
      pcF_q <= w_target;
      if (state_q != ST_IDLE) begin
        state_q <= bus.imem_rvalid ? ST_IDLE : ST_DISCARD;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_req && bus.imem_gnt) begin
            inflight_pc_q <= pcF_q;
            pcF_q         <= pcF_q + XLEN'(4);
            state_q       <= ST_WAIT;
          end
        end
        ST_WAIT, ST_DISCARD: begin
          if (bus.imem_rvalid) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // IF/ID register: flush > stall > pop > bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      instrD_q   <= NOP_INSTR;
      pcD_q      <= '0;
      pcplus4D_q <= '0;
      validD_q   <= 1'b0;
    end else if (bus.flushD) begin
      instrD_q <= NOP_INSTR;
      validD_q <= 1'b0;
    end else if (bus.stallD) begin
      validD_q <= validD_q;
    end else if (!w_fifo_empty) begin
      instrD_q   <= w_head.instr;
      pcD_q      <= w_head.pc;
      pcplus4D_q <= w_head.pc + XLEN'(4);
      validD_q   <= 1'b1;
    end else begin
      instrD_q <= NOP_INSTR;
      validD_q <= 1'b0;
    end
  end

  assign bus.instrD   = instrD_q;
  assign bus.pcD      = pcD_q;
  assign bus.pcplus4D = pcplus4D_q;
  assign bus.validD   = validD_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_discarded_q;
  logic [31:0] perf_bubbles_q;
  logic        w_drop_resp;
  logic        w_bubble;
  logic [32:0] w_disc_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [32:0] inc);
    logic [33:0] s;
    s = {2'b00, a} + {1'b0, inc};
    return (s > 34'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign w_drop_resp = bus.imem_rvalid &&
                       ((state_q == ST_DISCARD) || ((state_q == ST_WAIT) && w_redirect));
  assign w_disc_inc  = 33'(w_drop_resp) + (w_redirect ? 33'(w_fifo_count) : 33'd0);
  assign w_bubble    = bus.flushD || (!bus.stallD && w_fifo_empty);

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q   <= '0;
      perf_discarded_q <= '0;
      perf_bubbles_q   <= '0;
    end else begin
      perf_fetched_q   <= sat_add(perf_fetched_q, 33'(w_fifo_push));
      perf_discarded_q <= sat_add(perf_discarded_q, w_disc_inc);
      perf_bubbles_q   <= sat_add(perf_bubbles_q, 33'(w_bubble));
    end
  end

  assign perf_fetched_o   = perf_fetched_q;
  assign perf_discarded_o = perf_discarded_q;
  assign perf_bubbles_o   = perf_bubbles_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A memory responder grants
//            requests and returns words after a random latency; every granted
//            fetch pushes its expected {pc, instr} into a scoreboard queue and a
//            negedge monitor pops it when ID consumes a valid IF/ID entry.
//            Redirects and reset restart the expected instruction stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_discarded, perf_bubbles;
`endif

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (2),
    .NOP_INSTR (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched_o   (perf_fetched),
    .perf_discarded_o (perf_discarded),
    .perf_bubbles_o   (perf_bubbles)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  // memory responder / fetch-address model
  bit          mem_out = 1'b0;
  int          mem_dly = 0;
  logic [31:0] mem_addr = '0;
  logic [31:0] exp_fetch_pc = RST_PC;
  bit          last_req = 1'b0;
  bit          cap_first = 1'b0;
  bit          got_first = 1'b0;
  logic [31:0] first_gnt = '0;
  int          n_consumed = 0;
  logic [31:0] last_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock of stimulus plus the memory side of the handshake
  task automatic cycle(input bit r, input bit sF, input bit sD, input logic [1:0] psE,
                       input logic [31:0] tE, input logic [31:0] aE, input bit jD,
                       input logic [31:0] tD, input int gpct, input int maxd);
    bit          rv;
    bit          redir;
    bit          g;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    rst             = r;
    rv              = mem_out && (mem_dly == 0);
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem_word(mem_addr) : $urandom;
    redir           = !r && ((psE != 2'b00) || jD);
    bus.stallF      = sF;
    bus.stallD      = sD;
    bus.pcsrcE      = psE;
    bus.pctargetE   = tE;
    bus.aluresultE  = aE;
    bus.jalD        = jD;
    bus.pctargetD   = tD;
    bus.flushD      = redir;
    if (r) begin
      sbq.delete();
      exp_fetch_pc = RST_PC;
    end else if (redir) begin
      if (psE == 2'b10)      tgt = aE;
      else if (psE != 2'b00) tgt = tE;
      else                   tgt = tD;
      exp_fetch_pc = {tgt[31:2], 2'b00};
      sbq.delete();
    end
    #1;
    last_req     = bus.imem_req;
    g            = bus.imem_req && !mem_out && ($urandom_range(99) < gpct);
    bus.imem_gnt = g;
    if (g) begin
      chk("fetch_addr", bus.imem_addr, exp_fetch_pc);
      if (cap_first) begin
        first_gnt = bus.imem_addr;
        cap_first = 1'b0;
        got_first = 1'b1;
      end
      sbq.push_back('{pc: exp_fetch_pc, instr: mem_word(exp_fetch_pc)});
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    if (rv)           mem_out = 1'b0;
    else if (mem_out) mem_dly--;
    if (g) begin
      mem_out  = 1'b1;
      mem_dly  = $urandom_range(maxd);
      mem_addr = bus.imem_addr;
    end
  endtask

  task automatic idle(input int gpct, input int maxd);
    cycle(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, 1'b0, '0, gpct, maxd);
  endtask

  // Wait until a request is outstanding with at least min_dly cycles left
  task automatic wait_in_flight(input int min_dly, input int maxd);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mem_out && mem_dly >= min_dly) begin
        ok = 1'b1;
        break;
      end
      idle(100, maxd);
    end
    chk("reach_wait", {31'b0, ok}, 32'd1);
  endtask

  // Apply one redirect and check the first following fetch address
  task automatic redirect_check(input string name, input logic [1:0] psE, input logic [31:0] tE,
                                input logic [31:0] aE, input bit jD, input logic [31:0] tD,
                                input logic [31:0] exp_addr);
    cap_first = 1'b1;
    got_first = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, psE, tE, aE, jD, tD, 100, 3);
    for (int i = 0; i < 100 && !got_first; i++) idle(100, 3);
    chk({name, "_seen"}, {31'b0, got_first}, 32'd1);
    chk(name, first_gnt, exp_addr);
  endtask

  // Scoreboard monitor: an IF/ID entry is consumed when valid and not held/flushed
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.validD === 1'b1 && bus.stallD === 1'b0 && bus.flushD === 1'b0) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL consume_unexpected actual_pc=%h required=no_instruction", bus.pcD);
      end else begin
        e = sbq.pop_front();
        chk("pcD", bus.pcD, e.pc);
        chk("instrD", bus.instrD, e.instr);
        chk("pcplus4D", bus.pcplus4D, e.pc + 32'd4);
        n_consumed++;
        last_pc = bus.pcD;
      end
    end
  end

  initial begin : stim
    int          nc0;
    bit          ok;
    logic [31:0] held_pc;
    bit          sF, sD, jD;
    logic [1:0]  psE;
    bus.stallF = 0; bus.stallD = 0; bus.flushD = 0; bus.pcsrcE = 0;
    bus.pctargetE = 0; bus.aluresultE = 0; bus.jalD = 0; bus.pctargetD = 0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;

    // reset
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 2'b00, '0, '0, 1'b0, '0, 100, 0);
    chk("rst_req", {31'b0, last_req}, 32'd0);
    idle(100, 0);
    @(negedge clk);
    chk("rst_validD", {31'b0, bus.validD}, 32'd0);
    chk("rst_instrD", bus.instrD, NOP);
    chk("rst_pcD", bus.pcD, 32'd0);
    chk("rst_pcplus4D", bus.pcplus4D, 32'd0);

    // sequential fetch with an always-ready memory
    repeat (30) idle(100, 0);

    // ID stall: buffer fills and requests stop
    repeat (10) cycle(1'b0, 1'b0, 1'b1, 2'b00, '0, '0, 1'b0, '0, 100, 0);
    chk("stallD_req_low", {31'b0, last_req}, 32'd0);
    repeat (20) idle(100, 0);

    // branch redirect while waiting on memory
    wait_in_flight(1, 3);
    nc0 = n_consumed;
    redirect_check("br_addr", 2'b01, 32'h0000_0100, 32'h0, 1'b0, 32'h0, 32'h0000_0100);
    for (int i = 0; i < 100 && n_consumed == nc0; i++) idle(100, 3);
    chk("br_first_pcD", last_pc, 32'h0000_0100);

    // jalr beats jal; target low bits cleared
    redirect_check("jalr_over_jal", 2'b10, 32'h0000_0500, 32'h0000_0203, 1'b1, 32'h0000_0040,
                   32'h0000_0200);
    redirect_check("jal_addr", 2'b00, 32'h0, 32'h0, 1'b1, 32'h0000_0046, 32'h0000_0044);
    redirect_check("pcsrc11_addr", 2'b11, 32'h0000_0608, 32'h0000_0700, 1'b1, 32'h0000_0040,
                   32'h0000_0608);

    // flush together with stall
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      idle(100, 0);
      if (bus.validD === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_validD", {31'b0, ok}, 32'd1);
    held_pc = bus.pcD;
    cycle(1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_0300, '0, 1'b0, '0, 100, 0);
    idle(100, 0);
    @(negedge clk);
    chk("flush_instrD", bus.instrD, NOP);
    chk("flush_validD", {31'b0, bus.validD}, 32'd0);
    chk("flush_pcD_kept", bus.pcD, held_pc);

    // PC wraps around the top of the address space
    redirect_check("wrap_addr", 2'b01, 32'hFFFF_FFF9, '0, 1'b0, '0, 32'hFFFF_FFF8);
    nc0 = n_consumed;
    repeat (30) idle(100, 0);
    chk("wrap_progress", {31'b0, (n_consumed >= nc0 + 4)}, 32'd1);

    // reset while a fetch is in flight; its late response must be ignored
    wait_in_flight(2, 4);
    cycle(1'b1, 1'b0, 1'b0, 2'b00, '0, '0, 1'b0, '0, 100, 0);
    chk("rstw_req", {31'b0, last_req}, 32'd0);
    cap_first = 1'b1;
    got_first = 1'b0;
    idle(100, 0);
    @(negedge clk);
    chk("rstw_validD", {31'b0, bus.validD}, 32'd0);
    chk("rstw_instrD", bus.instrD, NOP);
    chk("rstw_pcD", bus.pcD, 32'd0);
    chk("rstw_pcplus4D", bus.pcplus4D, 32'd0);
    for (int i = 0; i < 100 && !got_first; i++) idle(100, 0);
    chk("rstw_first_addr", first_gnt, RST_PC);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sF  = ($urandom_range(9) == 0);
      sD  = ($urandom_range(4) == 0);
      psE = 2'b00;
      jD  = 1'b0;
      if ($urandom_range(24) == 0) begin
        psE = 2'($urandom_range(3));
        jD  = ($urandom_range(1) == 1) || (psE == 2'b00);
      end
      cycle(1'b0, sF, sD, psE, $urandom & 32'h0000_0FFF, $urandom & 32'h0000_0FFF, jD,
            $urandom & 32'h0000_0FFF, 70, 3);
    end
    repeat (20) idle(100, 0);
    chk("overall_progress", {31'b0, (n_consumed >= 300)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
